// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster timing bundle from the timing generator to the pixel colour stage.
//   The generator drives the bundle through the master modport. The colour
//   stage or any observer reads it through the slave modport.
//
//   hsync_o       horizontal sync, level set by the generator's H_POL
//   vsync_o       vertical sync, level set by the generator's V_POL
//   disp_active   current pixel lies in the visible area
//   xcol_o        current column (11 bits)
//   yrow_o        current row (11 bits)
//   frame_start_o high for the pixel at column 0, row 0
//   pix_tick_o    pixel advance strobe
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic        hsync_o;
    logic        vsync_o;
    logic        disp_active;
    logic [10:0] xcol_o;
    logic [10:0] yrow_o;
    logic        frame_start_o;
    logic        pix_tick_o;

    modport master (
        output hsync_o, vsync_o, disp_active, xcol_o, yrow_o,
               frame_start_o, pix_tick_o
    );

    modport slave (
        input  hsync_o, vsync_o, disp_active, xcol_o, yrow_o,
               frame_start_o, pix_tick_o
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator. Horizontal and vertical phase FSMs follow pixel
//   counters. Every output is registered on the same edge, so a given
//   (xcol_o, yrow_o) is always reported together with the flags for that
//   pixel. The default parameters give 640x480 at 60 Hz with a 25 MHz pixel
//   clock.
//
//   Ports
//     clk_i   system/pixel clock
//     rst_i   asynchronous active-high reset
//     vga     vga_timing_gen_if.master. This group carries hsync_o, vsync_o,
//             disp_active, xcol_o, yrow_o, frame_start_o and pix_tick_o.
//
//   Optional build macro: VGA_PIXEL_PREDIV_EN
//     When this macro is defined, a prescaler divides clk_i by CLK_DIV. The
//     raster then advances once every CLK_DIV clocks, and pix_tick_o marks
//     each advance. When it is not defined, every clk_i is a pixel and
//     pix_tick_o stays high outside reset.
//
//   H_TOTAL and V_TOTAL must each be at most 2048.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last counter value of each phase. A phase FSM steps when its counter
    // reaches the last value of the current phase.
    localparam logic [10:0] H_ACT_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] H_FP_LAST   = 11'(H_ACTIVE + H_FP - 1);
    localparam logic [10:0] H_SYNC_LAST = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [10:0] V_FP_LAST   = 11'(V_ACTIVE + V_FP - 1);
    localparam logic [10:0] V_SYNC_LAST = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t    h_state_q, h_state_d;
    v_state_t    v_state_q, v_state_d;
    logic [10:0] h_q, h_d, v_q, v_d;
    logic [10:0] xcol_q, xcol_d, yrow_q, yrow_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        disp_q, disp_d, fs_q, fs_d, tick_q, tick_d;
    logic        advance;
    logic        line_end;

`ifdef VGA_PIXEL_PREDIV_EN
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        advance = (presc_q == PRESC_LAST);
        presc_d = advance ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) presc_q <= '0;
        else       presc_q <= presc_d;
    end
`else
    assign advance = 1'b1;
`endif

    // The back porch's last pixel closes the line and clocks the vertical FSM.
    assign line_end = (h_state_q == HS_BP) && (h_q == H_LAST);

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (advance) begin
            h_d = line_end ? 11'd0 : h_q + 11'd1;
            unique case (h_state_q)
                HS_ACT:  if (h_q == H_ACT_LAST)  h_state_d = HS_FP;
                HS_FP:   if (h_q == H_FP_LAST)   h_state_d = HS_SYNC;
                HS_SYNC: if (h_q == H_SYNC_LAST) h_state_d = HS_BP;
                HS_BP:   if (line_end)           h_state_d = HS_ACT;
            endcase
            if (line_end) begin
                v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
                unique case (v_state_q)
                    VS_ACT:  if (v_q == V_ACT_LAST)  v_state_d = VS_FP;
                    VS_FP:   if (v_q == V_FP_LAST)   v_state_d = VS_SYNC;
                    VS_SYNC: if (v_q == V_SYNC_LAST) v_state_d = VS_BP;
                    VS_BP:   if (v_q == V_LAST)      v_state_d = VS_ACT;
                endcase
            end
        end
    end

    // The outputs are computed from the next-state values. They are then
    // registered on the same edge as the counters, which keeps every flag
    // aligned with the reported column and row. Between advances the outputs
    // hold their values.
    always_comb begin
        xcol_d  = xcol_q;
        yrow_d  = yrow_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        disp_d  = disp_q;
        fs_d    = fs_q;
        if (advance) begin
            xcol_d  = h_d;
            yrow_d  = v_d;
            hsync_d = (h_state_d == HS_SYNC) ? HS_ON : ~HS_ON;
            vsync_d = (v_state_d == VS_SYNC) ? VS_ON : ~VS_ON;
            disp_d  = (h_state_d == HS_ACT) && (v_state_d == VS_ACT);
            fs_d    = (h_d == 11'd0) && (v_d == 11'd0);
        end
        tick_d = advance;
    end

    // Reset parks the counters on the last pixel of the last line. The first
    // advance after release therefore lands on (0,0).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q       <= H_LAST;
            v_q       <= V_LAST;
            h_state_q <= HS_BP;
            v_state_q <= VS_BP;
            xcol_q    <= '0;
            yrow_q    <= '0;
            hsync_q   <= ~HS_ON;
            vsync_q   <= ~VS_ON;
            disp_q    <= 1'b0;
            fs_q      <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            xcol_q    <= xcol_d;
            yrow_q    <= yrow_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            disp_q    <= disp_d;
            fs_q      <= fs_d;
            tick_q    <= tick_d;
        end
    end

    assign vga.hsync_o       = hsync_q;
    assign vga.vsync_o       = vsync_q;
    assign vga.disp_active   = disp_q;
    assign vga.xcol_o        = xcol_q;
    assign vga.yrow_o        = yrow_q;
    assign vga.frame_start_o = fs_q;
    assign vga.pix_tick_o    = tick_q;

endmodule
